// File: rtl/conv3x3_engine.sv
// conv3x3_engine: four-stage 3x3 window convolution engine.
// Modes: 0 = Sobel binary edge, 1 = Sobel magnitude, 2 = box blur /9,
// 3 = Gaussian blur /16. A saturating counter tracks delivered edge pixels.
//
// Handshake: a window transfers in on a clock edge where DATA_VALID and
// IN_READY are both high. A result transfers out on a clock edge where
// DATAOUT_VALID and OUT_READY are both high. One global enable moves the
// whole pipeline. It is high when the output register is empty or is being
// drained this cycle, and IN_READY is that enable. While the enable is low,
// every stage holds its data, valid, mode and threshold. The output
// therefore stays stable until the downstream side takes it.
module conv3x3_engine #(
    parameter int PIX_W = 8,
    parameter int SQ_W  = 2*PIX_W+6,
    parameter int CNT_W = 20
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [9*PIX_W-1:0] PIXEL_DATA,
    input  logic               DATA_VALID,
    output logic               IN_READY,
    input  logic [1:0]         MODE,
    input  logic [SQ_W-1:0]    THRESH,
    output logic [PIX_W-1:0]   DATAOUT,
    output logic               DATAOUT_VALID,
    input  logic               OUT_READY,
    input  logic               CNT_CLR,
    output logic [CNT_W-1:0]   EDGE_COUNT
);
    // Signed width for gx, gy and the blur sums; it covers 16*(2^PIX_W-1).
    localparam int SW = PIX_W + 5;

    localparam logic [1:0] M_SOBEL_BIN = 2'd0;
    localparam logic [1:0] M_SOBEL_MAG = 2'd1;
    localparam logic [1:0] M_BOX       = 2'd2;

    // Left-shift amounts that give the Gaussian weights 1 2 1 / 2 4 2 / 1 2 1.
    localparam int G_SH [9] = '{0, 1, 0, 1, 2, 1, 0, 1, 0};

    logic en;
    assign en       = ~DATAOUT_VALID | OUT_READY;
    assign IN_READY = en;

    // ---------------- S1: signed products ----------------
    logic signed [SW-1:0] px    [9];
    logic signed [SW-1:0] p1_gx [6];
    logic signed [SW-1:0] p1_gy [6];
    logic signed [SW-1:0] p1_gs [9];

    logic signed [SW-1:0] s1_gx [6];
    logic signed [SW-1:0] s1_gy [6];
    logic signed [SW-1:0] s1_gs [9];
    logic signed [SW-1:0] s1_bx [9];
    logic                 s1_v;
    logic [1:0]           s1_mode;
    logic [SQ_W-1:0]      s1_thresh;

    // Zero-extend the pixels and form the non-zero kernel terms.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            px[k]    = $signed({5'b0, PIXEL_DATA[k*PIX_W +: PIX_W]});
            p1_gs[k] = px[k] <<< G_SH[k];
        end
        p1_gx[0] = px[0];
        p1_gx[1] = -px[2];
        p1_gx[2] = px[3] <<< 1;
        p1_gx[3] = -(px[5] <<< 1);
        p1_gx[4] = px[6];
        p1_gx[5] = -px[8];
        p1_gy[0] = px[0];
        p1_gy[1] = px[1] <<< 1;
        p1_gy[2] = px[2];
        p1_gy[3] = -px[6];
        p1_gy[4] = -(px[7] <<< 1);
        p1_gy[5] = -px[8];
    end

    // S1 register: the products, with mode and threshold captured at transfer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 6; i++) begin
                s1_gx[i] <= '0;
                s1_gy[i] <= '0;
            end
            for (int i = 0; i < 9; i++) begin
                s1_gs[i] <= '0;
                s1_bx[i] <= '0;
            end
            s1_v      <= 1'b0;
            s1_mode   <= '0;
            s1_thresh <= '0;
        end else if (en) begin
            s1_gx     <= p1_gx;
            s1_gy     <= p1_gy;
            s1_gs     <= p1_gs;
            s1_bx     <= px;
            s1_v      <= DATA_VALID;
            s1_mode   <= MODE;
            s1_thresh <= THRESH;
        end
    end

    // ---------------- S2: adder tree ----------------
    logic signed [SW-1:0] sum_gx, sum_gy, sum_gs, sum_bx;
    logic signed [SW-1:0] s2_gx, s2_gy, s2_gs, s2_bx;
    logic                 s2_v;
    logic [1:0]           s2_mode;
    logic [SQ_W-1:0]      s2_thresh;

    // Reduce each product set to one signed sum.
    always_comb begin
        sum_gx = '0;
        sum_gy = '0;
        sum_gs = '0;
        sum_bx = '0;
        for (int i = 0; i < 6; i++) begin
            sum_gx = sum_gx + s1_gx[i];
            sum_gy = sum_gy + s1_gy[i];
        end
        for (int i = 0; i < 9; i++) begin
            sum_gs = sum_gs + s1_gs[i];
            sum_bx = sum_bx + s1_bx[i];
        end
    end

    // S2 register: the four sums, with mode and threshold.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s2_gx     <= '0;
            s2_gy     <= '0;
            s2_gs     <= '0;
            s2_bx     <= '0;
            s2_v      <= 1'b0;
            s2_mode   <= '0;
            s2_thresh <= '0;
        end else if (en) begin
            s2_gx     <= sum_gx;
            s2_gy     <= sum_gy;
            s2_gs     <= sum_gs;
            s2_bx     <= sum_bx;
            s2_v      <= s1_v;
            s2_mode   <= s1_mode;
            s2_thresh <= s1_thresh;
        end
    end

    // ---------------- S3: per-mode arithmetic ----------------
    logic signed [SQ_W-1:0] gx_w, gy_w;
    logic [SW-1:0]          abs_gx, abs_gy, box_u, gs_u;
    logic [SQ_W-1:0]        s3_val_d;
    logic [SQ_W-1:0]        s3_val;
    logic                   s3_v;
    logic [1:0]             s3_mode;
    logic [SQ_W-1:0]        s3_thresh;

    // Mode 0 forms gx^2+gy^2 and mode 1 forms |gx|+|gy|. The blur modes
    // divide their sums. All modes share one wide result field.
    always_comb begin
        gx_w     = SQ_W'(s2_gx);
        gy_w     = SQ_W'(s2_gy);
        abs_gx   = (s2_gx < 0) ? $unsigned(-s2_gx) : $unsigned(s2_gx);
        abs_gy   = (s2_gy < 0) ? $unsigned(-s2_gy) : $unsigned(s2_gy);
        box_u    = $unsigned(s2_bx);
        gs_u     = $unsigned(s2_gs);
        s3_val_d = '0;
        case (s2_mode)
            M_SOBEL_BIN: s3_val_d = $unsigned(gx_w * gx_w) + $unsigned(gy_w * gy_w);
            M_SOBEL_MAG: s3_val_d = SQ_W'(abs_gx + abs_gy);
            M_BOX:       s3_val_d = SQ_W'(box_u / SW'(9));
            default:     s3_val_d = SQ_W'((gs_u + SW'(8)) >> 4);
        endcase
    end

    // S3 register: the mode result, with mode and threshold.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s3_val    <= '0;
            s3_v      <= 1'b0;
            s3_mode   <= '0;
            s3_thresh <= '0;
        end else if (en) begin
            s3_val    <= s3_val_d;
            s3_v      <= s2_v;
            s3_mode   <= s2_mode;
            s3_thresh <= s2_thresh;
        end
    end

    // ---------------- S4: output register ----------------
    logic [PIX_W-1:0] out_d;
    logic [1:0]       out_mode;

    // Mode 0 applies a strict threshold and mode 1 saturates.
    // The blur results already fit in one pixel.
    always_comb begin
        out_d = '0;
        case (s3_mode)
            M_SOBEL_BIN: out_d = (s3_val > s3_thresh) ? '1 : '0;
            M_SOBEL_MAG: out_d = (|s3_val[SQ_W-1:PIX_W]) ? '1 : s3_val[PIX_W-1:0];
            default:     out_d = s3_val[PIX_W-1:0];
        endcase
    end

    // S4 register: the result pixel, its valid, and its mode for the edge counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DATAOUT       <= '0;
            DATAOUT_VALID <= 1'b0;
            out_mode      <= '0;
        end else if (en) begin
            DATAOUT       <= out_d;
            DATAOUT_VALID <= s3_v;
            out_mode      <= s3_mode;
        end
    end

    // ---------------- Edge statistics ----------------
    logic edge_hit;
    assign edge_hit = DATAOUT_VALID & OUT_READY & (out_mode == M_SOBEL_BIN) & (&DATAOUT);

    // The counter counts each delivered edge pixel once and saturates at the top.
    // A clear wins over an increment in the same cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            EDGE_COUNT <= '0;
        end else if (CNT_CLR) begin
            EDGE_COUNT <= '0;
        end else if (edge_hit && !(&EDGE_COUNT)) begin
            EDGE_COUNT <= EDGE_COUNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_conv3x3_engine.sv
// tb_conv3x3_engine: directed checks of conv3x3_engine with a scoreboard queue.
// Expected pixels come from an independent integer model of the kernels.
module tb_conv3x3_engine;
    localparam int PIX_W = 8;
    localparam int SQ_W  = 2*PIX_W+6;
    localparam int CNT_W = 20;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [9*PIX_W-1:0] PIXEL_DATA;
    logic               DATA_VALID;
    logic               IN_READY;
    logic [1:0]         MODE;
    logic [SQ_W-1:0]    THRESH;
    logic [PIX_W-1:0]   DATAOUT;
    logic               DATAOUT_VALID;
    logic               OUT_READY;
    logic               CNT_CLR;
    logic [CNT_W-1:0]   EDGE_COUNT;

    logic               in_ready_b;
    logic [PIX_W-1:0]   dataout_b;
    logic               dataout_valid_b;
    logic [2:0]         edge_count_b;

    conv3x3_engine #(.PIX_W(PIX_W), .SQ_W(SQ_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .PIXEL_DATA(PIXEL_DATA), .DATA_VALID(DATA_VALID),
        .IN_READY(IN_READY), .MODE(MODE), .THRESH(THRESH), .DATAOUT(DATAOUT),
        .DATAOUT_VALID(DATAOUT_VALID), .OUT_READY(OUT_READY), .CNT_CLR(CNT_CLR),
        .EDGE_COUNT(EDGE_COUNT)
    );

    // Narrow-counter copy that shares all inputs, used for saturation.
    conv3x3_engine #(.PIX_W(PIX_W), .SQ_W(SQ_W), .CNT_W(3)) dut_sat (
        .CLK(CLK), .RST_N(RST_N), .PIXEL_DATA(PIXEL_DATA), .DATA_VALID(DATA_VALID),
        .IN_READY(in_ready_b), .MODE(MODE), .THRESH(THRESH), .DATAOUT(dataout_b),
        .DATAOUT_VALID(dataout_valid_b), .OUT_READY(OUT_READY), .CNT_CLR(CNT_CLR),
        .EDGE_COUNT(edge_count_b)
    );

    // ---------------- scoreboard state ----------------
    logic [PIX_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int last_xfer_cyc = 0;
    int last_out_cyc  = 0;
    int n_out         = 0;
    int stall_cnt     = 0;
    int rdy_low_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Independent reference: the integer kernel math for one window.
    function automatic logic [PIX_W-1:0] model(input logic [9*PIX_W-1:0] w,
                                               input logic [1:0] m,
                                               input logic [SQ_W-1:0] th);
        int p [9];
        int gx, gy, a, s, g;
        for (int k = 0; k < 9; k++) p[k] = int'(w[k*PIX_W +: PIX_W]);
        gx = p[0] + 2*p[3] + p[6] - p[2] - 2*p[5] - p[8];
        gy = p[0] + 2*p[1] + p[2] - p[6] - 2*p[7] - p[8];
        s  = p[0] + p[1] + p[2] + p[3] + p[4] + p[5] + p[6] + p[7] + p[8];
        g  = p[0] + 2*p[1] + p[2] + 2*p[3] + 4*p[4] + 2*p[5] + p[6] + 2*p[7] + p[8];
        case (m)
            2'd0: return ((gx*gx + gy*gy) > int'(th)) ? 8'hFF : 8'h00;
            2'd1: begin
                a = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                return (a > 255) ? 8'hFF : 8'(a);
            end
            2'd2: return 8'(s / 9);
            default: return 8'((g + 8) / 16);
        endcase
    endfunction

    function automatic logic [9*PIX_W-1:0] pack(input int a [9]);
        logic [9*PIX_W-1:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w[k*PIX_W +: PIX_W] = PIX_W'(a[k]);
        return w;
    endfunction

    // ---------------- driver tasks ----------------
    // Present one window and hold it until it is accepted. The expected
    // pixel is queued at acceptance. The task returns 1 time unit after
    // the transfer edge.
    task automatic send(input logic [9*PIX_W-1:0] w, input logic [1:0] m,
                        input logic [SQ_W-1:0] th);
        int waited = 0;
        PIXEL_DATA = w;
        MODE       = m;
        THRESH     = th;
        DATA_VALID = 1'b1;
        forever begin
            @(negedge CLK);
            if (IN_READY) break;
            waited++;
            if (waited > 50) begin
                checks++;
                errors++;
                $error("FAIL send_timeout observed=not_accepted expected=accepted");
                DATA_VALID = 1'b0;
                return;
            end
            @(posedge CLK);
        end
        exp_q.push_back(model(w, m, th));
        last_xfer_cyc = cyc;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        DATA_VALID = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge CLK);
        #1;
    endtask

    // ---------------- output monitor ----------------
    logic             held = 1'b0;
    logic [PIX_W-1:0] held_val = '0;

    always @(negedge CLK) begin
        if (!RST_N) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", DATAOUT_VALID, 1);
                check("hold_data", DATAOUT, held_val);
            end
            if (DATAOUT_VALID) check("in_ready_busy", IN_READY, OUT_READY);
            else               check("in_ready_idle", IN_READY, 1);
            if (!IN_READY) rdy_low_cnt++;
            if (DATAOUT_VALID && !OUT_READY) stall_cnt++;
            if (DATAOUT_VALID && OUT_READY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_out observed=%0d expected=none", DATAOUT);
                end else begin
                    check("dataout", DATAOUT, exp_q.pop_front());
                end
                n_out++;
                last_out_cyc = cyc;
            end
            held     = DATAOUT_VALID && !OUT_READY;
            held_val = DATAOUT;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    int wa [9];
    int stall0, rdy0, nout0;
    logic [9*PIX_W-1:0] edge_w;

    initial begin
        RST_N      = 1'b0;
        PIXEL_DATA = '0;
        DATA_VALID = 1'b0;
        MODE       = 2'd0;
        THRESH     = '0;
        OUT_READY  = 1'b1;
        CNT_CLR    = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_valid", DATAOUT_VALID, 0);
        check("rst_data", DATAOUT, 0);
        check("rst_count", EDGE_COUNT, 0);
        check("rst_in_ready", IN_READY, 1);
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // Flat window in three modes, then check the latency of the last one.
        for (int k = 0; k < 9; k++) wa[k] = 100;
        send(pack(wa), 2'd0, SQ_W'(4000)); idle(); drain();
        check("latency_flat", last_out_cyc - last_xfer_cyc, 4);
        send(pack(wa), 2'd2, SQ_W'(4000)); idle(); drain();
        send(pack(wa), 2'd3, SQ_W'(4000)); idle(); drain();

        // Strong left edge: both threshold sides and magnitude saturation.
        wa = '{255, 0, 0, 255, 0, 0, 255, 0, 0};
        edge_w = pack(wa);
        send(edge_w, 2'd0, SQ_W'(4000));    idle(); drain();
        send(edge_w, 2'd0, SQ_W'(1040400)); idle(); drain();
        send(edge_w, 2'd1, SQ_W'(0));       idle(); drain();

        // Blur boundaries.
        for (int k = 0; k < 9; k++) wa[k] = k * 10;
        send(pack(wa), 2'd2, '0); idle(); drain();
        for (int k = 0; k < 9; k++) wa[k] = 255;
        send(pack(wa), 2'd2, '0); idle(); drain();
        wa = '{8, 0, 0, 0, 0, 0, 0, 0, 0};
        send(pack(wa), 2'd2, '0); idle(); drain();
        wa = '{0, 0, 0, 0, 4, 0, 0, 0, 0};
        send(pack(wa), 2'd3, '0); idle(); drain();

        // Ten back-to-back random windows. The mode changes on every
        // window, and OUT_READY drops for 3 cycles in the middle.
        stall0 = stall_cnt;
        rdy0   = rdy_low_cnt;
        nout0  = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    for (int k = 0; k < 9; k++) wa[k] = int'($urandom_range(0, 255));
                    send(pack(wa), 2'(i % 4), SQ_W'($urandom_range(0, 300000)));
                end
                idle();
            end
            begin
                repeat (6) @(posedge CLK);
                #1 OUT_READY = 1'b0;
                repeat (3) @(posedge CLK);
                #1 OUT_READY = 1'b1;
            end
        join
        drain();
        check("burst_count", n_out - nout0, 10);
        check("burst_stalls", stall_cnt - stall0, 3);
        check("burst_rdy_low", rdy_low_cnt - rdy0, 3);

        // Edge counter: five edges, then a clear in the same cycle as the
        // transfer of a sixth edge that was held under a stall.
        CNT_CLR = 1'b1;
        @(posedge CLK);
        #1 CNT_CLR = 1'b0;
        check("cnt_cleared", EDGE_COUNT, 0);
        for (int i = 0; i < 5; i++) send(edge_w, 2'd0, SQ_W'(4000));
        idle(); drain();
        check("cnt_five", EDGE_COUNT, 5);
        check("cnt_five_sat", edge_count_b, 5);
        OUT_READY = 1'b0;
        send(edge_w, 2'd0, SQ_W'(4000)); idle();
        for (int n = 0; n < 20 && !DATAOUT_VALID; n++) @(posedge CLK);
        #1;
        check("sixth_waiting", DATAOUT_VALID, 1);
        repeat (2) @(posedge CLK);
        #1;
        check("cnt_held_once", EDGE_COUNT, 5);
        OUT_READY = 1'b1;
        CNT_CLR   = 1'b1;
        @(posedge CLK);
        #1 CNT_CLR = 1'b0;
        check("cnt_clr_wins", EDGE_COUNT, 0);
        check("exp_after_clr", exp_q.size(), 0);

        // Nine edges saturate the 3-bit counter at 7.
        for (int i = 0; i < 9; i++) send(edge_w, 2'd0, SQ_W'(4000));
        idle(); drain();
        check("cnt_nine", EDGE_COUNT, 9);
        check("cnt_saturate", edge_count_b, 7);

        // Reset with three windows in flight.
        for (int i = 0; i < 3; i++) send(edge_w, 2'd0, SQ_W'(4000));
        idle();
        #2 RST_N = 1'b0;
        #1;
        check("mid_rst_valid", DATAOUT_VALID, 0);
        check("mid_rst_data", DATAOUT, 0);
        check("mid_rst_count", EDGE_COUNT, 0);
        exp_q.delete();
        nout0 = n_out;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        check("no_stale_out", n_out - nout0, 0);
        for (int k = 0; k < 9; k++) wa[k] = k * 10;
        send(pack(wa), 2'd2, '0); idle(); drain();
        check("post_rst_count", n_out - nout0, 1);
        check("latency_post_rst", last_out_cyc - last_xfer_cyc, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv3x3_engine.md
Name: conv3x3_engine

Overview:
- Parametrised 3x3 window convolution engine; next generation of the fixed Sobel MAC stage.
- Consumes one packed 3x3 pixel window per accepted transfer and produces one output pixel.
- Four runtime-selectable modes: Sobel binary edge, Sobel magnitude, box blur, Gaussian blur.
- Adds a valid/ready stall path for the downstream frame writer and a saturating edge-pixel counter for statistics.

Parameters:
- PIX_W, 8, pixel width in bits (unsigned).
- SQ_W, 2*PIX_W+6, width of THRESH and of the internal gx^2+gy^2 sum.
- CNT_W, 20, EDGE_COUNT width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- PIXEL_DATA  in  9*PIX_W  window; element k (k=0..8, row-major, k=0 top-left) at bits [k*PIX_W +: PIX_W].
- DATA_VALID  in  1  window valid.
- IN_READY  out  1  engine accepts window this cycle.
- MODE  in  2  0=Sobel binary, 1=Sobel magnitude, 2=box /9, 3=Gaussian /16.
- THRESH  in  SQ_W  Sobel binary threshold.
- DATAOUT  out  PIX_W  result pixel.
- DATAOUT_VALID  out  1  result valid.
- OUT_READY  in  1  downstream accepts result.
- CNT_CLR  in  1  synchronous clear of EDGE_COUNT.
- EDGE_COUNT  out  CNT_W  count of accepted mode-0 outputs equal to all-ones.

Behaviour:
- Reset (async assert, sync deassert by upstream): all stage valids 0, DATAOUT=0, DATAOUT_VALID=0, EDGE_COUNT=0. In-flight windows are discarded. IN_READY=1 after reset.
- Handshake and stalls:
  - Transfer in: DATA_VALID & IN_READY. Transfer out: DATAOUT_VALID & OUT_READY.
  - Global advance en = ~DATAOUT_VALID | OUT_READY; IN_READY = en (combinational from OUT_READY and DATAOUT_VALID).
  - When en=0 every stage, including its data, valid, mode and threshold, holds.
  - DATAOUT and DATAOUT_VALID stay stable while DATAOUT_VALID=1 and OUT_READY=0.
  - Bubbles propagate as valid=0; no reordering, no drops, no duplicates.
- MODE and THRESH are sampled at input transfer and travel with the window. A mode change mid-stream applies per window.
- Pipeline, latency 4 cycles from input transfer to DATAOUT_VALID with no stalls:
  - S1: signed products, gx kernel [1 0 -1; 2 0 -2; 1 0 -1], gy kernel [1 2 1; 0 0 0; -1 -2 -1]; box weights all 1; Gaussian weights [1 2 1; 2 4 2; 1 2 1]. Pixels are zero-extended before signed math.
  - S2: adder tree. gx, gy, box sum and Gaussian sum are held in signed PIX_W+5 bits; no overflow is possible.
  - S3: mode 0 computes gx^2+gy^2 in SQ_W unsigned. Mode 1 computes |gx|+|gy|. Mode 2 computes floor(sum/9), exact (constant multiply-shift allowed if bit-exact for all inputs). Mode 3 computes (sum+8)>>4.
  - S4: output register.
    - Mode 0: all-ones if sq > THRESH (strict), else 0.
    - Mode 1: saturate to 2^PIX_W-1.
    - Modes 2 and 3: result always fits in PIX_W.
- EDGE_COUNT:
  - Increments on an output transfer where the result pixel's mode was 0 and DATAOUT is all-ones.
  - Saturates at 2^CNT_W-1; no wrap.
  - CNT_CLR takes precedence over a same-cycle increment, giving 0.
  - An output held under stall is counted once, at transfer.

Test Plan:
- Flat window (all pixels 100), MODE=0, THRESH=4000, OUT_READY=1 -> DATAOUT=0x00 exactly 4 cycles after transfer. MODE=2 -> 100. MODE=3 -> 100.
- Left column 255, rest 0: gx=1020, gy=0, sq=1040400. MODE=0, THRESH=4000 -> 0xFF. THRESH=1040400 -> 0x00 (strict compare). MODE=1 -> 255 (saturated).
- Box blur on window k*10 (0,10..80): sum=360 -> 40. All 255 -> 255. Sum 8 (one pixel 8) -> 0 (floor). Gaussian with centre 4, rest 0: (16+8)>>4 -> 1.
- Back-to-back 10 windows, OUT_READY low for 3 cycles mid-stream -> IN_READY low in the same cycles, DATAOUT held stable, all 10 results delivered in order with none lost or duplicated. MODE toggled each window -> each result follows its own mode.
- 5 edge windows in MODE=0, then CNT_CLR pulsed in the same cycle as a 6th edge output transfer -> EDGE_COUNT=5 then 0. Forced saturation with CNT_W=3 -> holds at 7.
- RST_N asserted with 3 windows in flight -> DATAOUT_VALID=0, DATAOUT=0, EDGE_COUNT=0 immediately. After release, no stale results emerge; the first new window's result appears 4 cycles after its transfer.
